// File: rtl/rgb_to_yuv422_if.sv
// Video stream bundle between an RGB888 source and the 4:2:2 encoder.
// The master drives the RGB timing/data and observes the YUV result.
// The slave (the encoder) consumes RGB and produces YUV.
interface rgb_to_yuv422_if;
   logic        rgb_hs;
   logic        rgb_vs;
   logic        rgb_de;
   logic [23:0] rgb_dat;
   logic        yuv_hs;
   logic        yuv_vs;
   logic        yuv_de;
   logic [9:0]  yuv_y;
   logic [9:0]  yuv_c;

   modport master (
      output rgb_hs, rgb_vs, rgb_de, rgb_dat,
      input  yuv_hs, yuv_vs, yuv_de, yuv_y, yuv_c
   );

   modport slave (
      input  rgb_hs, rgb_vs, rgb_de, rgb_dat,
      output yuv_hs, yuv_vs, yuv_de, yuv_y, yuv_c
   );
endinterface

// File: rtl/rgb_to_yuv422.sv
// RGB888 -> 10-bit YUV 4:2:2 encoder, BT.601 limited range.
// Four-stage pipeline: multiply, sum/round/clamp, pair hold, output.
// Chroma is either pair-averaged (CHROMA_AVG=1) or co-sited (CHROMA_AVG=0).
// A phase bit travels with every pixel; it restarts at even on each de rise,
// so a pair never spans a de-low gap.
module rgb_to_yuv422 #(
   parameter int CHROMA_AVG = 1
) (
   input logic            clk,
   input logic            rst,
   input logic            cke,
   rgb_to_yuv422_if.slave vid
);

   localparam bit         AVG     = (CHROMA_AVG != 0);
   localparam logic [9:0] Y_BLANK = 10'd64;
   localparam logic [9:0] C_BLANK = 10'd512;

   typedef logic signed [21:0] acc_t;

   // Signed product of an unsigned 8-bit channel and a signed coefficient.
   function automatic acc_t mul(input logic [7:0] x, input int k);
      return acc_t'(k * int'(x));
   endfunction

   // Drop the 10 fractional bits and saturate to the 10-bit code range.
   function automatic logic [9:0] sat(input acc_t acc);
      acc_t sh;
      sh = acc >>> 10;
      if (sh < 0)
         return 10'd0;
      if (sh > acc_t'(1023))
         return 10'd1023;
      return sh[9:0];
   endfunction

   logic [7:0] r_in, g_in, b_in;
   assign r_in = vid.rgb_dat[23:16];
   assign g_in = vid.rgb_dat[15:8];
   assign b_in = vid.rgb_dat[7:0];

   // ---------------------------------------------------------------------
   // Pixel phase at the input: even on a de rise, toggling while de stays high.
   logic de_q, ph_q, ph_in;

   // Phase of the sample currently on the input.
   // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
   always_comb begin
      ph_in = (vid.rgb_de && de_q) ? ~ph_q : 1'b0;
   end

   // ---------------------------------------------------------------------
   // Stage 1 state: nine signed products plus timing and phase.
   acc_t m_yr, m_yg, m_yb;
   acc_t m_ur, m_ug, m_ub;
   acc_t m_vr, m_vg, m_vb;
   logic hs1, vs1, de1, ph1;

   // Stage 1: register the channel products and the phase history.
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_q <= 1'b0;
         ph_q <= 1'b0;
         hs1  <= 1'b0;
         vs1  <= 1'b0;
         de1  <= 1'b0;
         ph1  <= 1'b0;
         m_yr <= '0; m_yg <= '0; m_yb <= '0;
         m_ur <= '0; m_ug <= '0; m_ub <= '0;
         m_vr <= '0; m_vg <= '0; m_vb <= '0;
      end else if (cke) begin
         de_q <= vid.rgb_de;
         ph_q <= ph_in;
         hs1  <= vid.rgb_hs;
         vs1  <= vid.rgb_vs;
         de1  <= vid.rgb_de;
         ph1  <= ph_in;
         m_yr <= mul(r_in,  1052);
         m_yg <= mul(g_in,  2065);
         m_yb <= mul(b_in,   401);
         m_ur <= mul(r_in,  -607);
         m_ug <= mul(g_in, -1192);
         m_ub <= mul(b_in,  1799);
         m_vr <= mul(r_in,  1799);
         m_vg <= mul(g_in, -1506);
         m_vb <= mul(b_in,  -293);
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: sum with offset (+16/+128 scaled, +512 rounding) then clamp.
   acc_t acc_y, acc_u, acc_v;

   // Accumulate the three products of each component.
   always_comb begin
      acc_y = m_yr + m_yg + m_yb + acc_t'(66048);
      acc_u = m_ur + m_ug + m_ub + acc_t'(524800);
      acc_v = m_vr + m_vg + m_vb + acc_t'(524800);
   end

   logic [9:0] y2, cb2, cr2;
   logic       hs2, vs2, de2, ph2;

   // Stage 2: register the rounded, saturated Y/Cb/Cr.
   always_ff @(posedge clk) begin
      if (rst) begin
         y2  <= '0;
         cb2 <= '0;
         cr2 <= '0;
         hs2 <= 1'b0;
         vs2 <= 1'b0;
         de2 <= 1'b0;
         ph2 <= 1'b0;
      end else if (cke) begin
         y2  <= sat(acc_y);
         cb2 <= sat(acc_u);
         cr2 <= sat(acc_v);
         hs2 <= hs1;
         vs2 <= vs1;
         de2 <= de1;
         ph2 <= ph1;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 3: hold the current pixel while stage 2 provides its look-ahead partner.
   logic [9:0] y3, cb3, cr3;
   logic       hs3, vs3, de3, ph3;

   // Stage 3: pixel under pairing decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         y3  <= '0;
         cb3 <= '0;
         cr3 <= '0;
         hs3 <= 1'b0;
         vs3 <= 1'b0;
         de3 <= 1'b0;
         ph3 <= 1'b0;
      end else if (cke) begin
         y3  <= y2;
         cb3 <= cb2;
         cr3 <= cr2;
         hs3 <= hs2;
         vs3 <= vs2;
         de3 <= de2;
         ph3 <= ph2;
      end
   end

   // An odd sample in stage 2 is necessarily the partner of an even sample in
   // stage 3, because phase restarts at even after any de-low gap.
   logic       pair_avg;
   logic [9:0] cb_avg, cr_avg;

   // Look-ahead averaging of the even/odd pair, rounding half up.
   always_comb begin
      pair_avg = AVG && de2 && ph2;
      cb_avg   = 10'(({1'b0, cb3} + {1'b0, cb2} + 11'd1) >> 1);
      cr_avg   = 10'(({1'b0, cr3} + {1'b0, cr2} + 11'd1) >> 1);
   end

   // ---------------------------------------------------------------------
   // Stage 4: output register; chroma multiplexing and blanking levels.
   logic [9:0] cr_hold;

   // Output stage: even pixels emit Cb and latch the pair's Cr for the odd pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         cr_hold    <= C_BLANK;
         vid.yuv_hs <= 1'b0;
         vid.yuv_vs <= 1'b0;
         vid.yuv_de <= 1'b0;
         vid.yuv_y  <= Y_BLANK;
         vid.yuv_c  <= C_BLANK;
      end else if (cke) begin
         vid.yuv_hs <= hs3;
         vid.yuv_vs <= vs3;
         vid.yuv_de <= de3;
         if (!de3) begin
            vid.yuv_y <= Y_BLANK;
            vid.yuv_c <= C_BLANK;
         end else if (!ph3) begin
            vid.yuv_y <= y3;
            vid.yuv_c <= pair_avg ? cb_avg : cb3;
            cr_hold   <= pair_avg ? cr_avg : cr3;
         end else begin
            vid.yuv_y <= y3;
            vid.yuv_c <= cr_hold;
         end
      end
   end

endmodule

// File: tb/tb_rgb_to_yuv422.sv
// Self-checking bench for rgb_to_yuv422: an averaging and a co-sited instance
// share one stimulus stream; a reference model pushes expected outputs into
// per-instance queues, which are popped on every enabled edge.
module tb_rgb_to_yuv422;

   logic clk = 1'b0;
   logic rst;
   logic cke;

   always #5 clk = ~clk;

   rgb_to_yuv422_if vif_a ();
   rgb_to_yuv422_if vif_c ();

   rgb_to_yuv422 #(.CHROMA_AVG(1)) dut_avg (
      .clk (clk),
      .rst (rst),
      .cke (cke),
      .vid (vif_a)
   );

   rgb_to_yuv422 #(.CHROMA_AVG(0)) dut_cos (
      .clk (clk),
      .rst (rst),
      .cke (cke),
      .vid (vif_c)
   );

   typedef struct {
      logic       de, hs, vs, ph;
      logic [7:0] r, g, b;
   } samp_t;

   localparam logic [32:0] BLANK = {3'b000, 10'd64, 10'd512};

   localparam logic [23:0] WHITE = 24'hFFFFFF;
   localparam logic [23:0] BLACK = 24'h000000;
   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] GREEN = 24'h00FF00;
   localparam logic [23:0] BLUE  = 24'h0000FF;

   logic [32:0] q_avg[$];
   logic [32:0] q_cos[$];
   logic [32:0] last_avg, last_cos;
   samp_t       pend;
   logic        have_pend;
   logic        prev_de, prev_ph;
   logic [9:0]  hold_avg, hold_cos;
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;

   // Reference arithmetic straight from the conversion equations.
   function automatic logic [9:0] clamp10(input int acc);
      int v;
      v = acc >>> 10;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      return 10'(v);
   endfunction

   function automatic logic [9:0] f_y(input samp_t s);
      return clamp10(1052 * int'(s.r) + 2065 * int'(s.g) + 401 * int'(s.b) + 66048);
   endfunction

   function automatic logic [9:0] f_cb(input samp_t s);
      return clamp10(-607 * int'(s.r) - 1192 * int'(s.g) + 1799 * int'(s.b) + 524800);
   endfunction

   function automatic logic [9:0] f_cr(input samp_t s);
      return clamp10(1799 * int'(s.r) - 1506 * int'(s.g) - 293 * int'(s.b) + 524800);
   endfunction

   function automatic logic [9:0] avg2(input logic [9:0] a, input logic [9:0] b);
      return 10'((int'(a) + int'(b) + 1) / 2);
   endfunction

   // Build the expected outputs of sample p once its successor n is known.
   task automatic finalize(input samp_t p, input samp_t n);
      logic [9:0] y, ca, cc;
      logic       partner;
      if (!p.de) begin
         y  = 10'd64;
         ca = 10'd512;
         cc = 10'd512;
      end else begin
         y = f_y(p);
         if (!p.ph) begin
            partner  = n.de && n.ph;
            ca       = partner ? avg2(f_cb(p), f_cb(n)) : f_cb(p);
            hold_avg = partner ? avg2(f_cr(p), f_cr(n)) : f_cr(p);
            cc       = f_cb(p);
            hold_cos = f_cr(p);
         end else begin
            ca = hold_avg;
            cc = hold_cos;
         end
      end
      q_avg.push_back({p.hs, p.vs, p.de, y, ca});
      q_cos.push_back({p.hs, p.vs, p.de, y, cc});
   endtask

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed={hs,vs,de,y,c}=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at the falling edge, sample outputs 1 ns after the rising edge.
   task automatic step(input logic rst_v, input logic en, input logic de,
                       input logic hs, input logic vs, input logic [23:0] dat);
      samp_t s;
      @(negedge clk);
      rst = rst_v;
      cke = en;
      vif_a.rgb_de = de;  vif_a.rgb_hs = hs;  vif_a.rgb_vs = vs;  vif_a.rgb_dat = dat;
      vif_c.rgb_de = de;  vif_c.rgb_hs = hs;  vif_c.rgb_vs = vs;  vif_c.rgb_dat = dat;
      @(posedge clk);
      #1;
      if (rst_v) begin
         prev_de   = 1'b0;
         prev_ph   = 1'b0;
         have_pend = 1'b0;
         q_avg.delete();
         q_cos.delete();
         for (int i = 0; i < 3; i++) begin
            q_avg.push_back(BLANK);
            q_cos.push_back(BLANK);
         end
         last_avg = BLANK;
         last_cos = BLANK;
         check("reset_avg", {vif_a.yuv_hs, vif_a.yuv_vs, vif_a.yuv_de, vif_a.yuv_y, vif_a.yuv_c}, BLANK);
         check("reset_cos", {vif_c.yuv_hs, vif_c.yuv_vs, vif_c.yuv_de, vif_c.yuv_y, vif_c.yuv_c}, BLANK);
      end else if (en) begin
         s.de = de;  s.hs = hs;  s.vs = vs;
         s.r  = dat[23:16];  s.g = dat[15:8];  s.b = dat[7:0];
         s.ph = (de && prev_de) ? ~prev_ph : 1'b0;
         prev_de = de;
         prev_ph = s.ph;
         if (have_pend) finalize(pend, s);
         pend      = s;
         have_pend = 1'b1;
         if (q_avg.size() == 0 || q_cos.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=empty expected=entry");
         end else begin
            last_avg = q_avg.pop_front();
            last_cos = q_cos.pop_front();
            check("pix_avg", {vif_a.yuv_hs, vif_a.yuv_vs, vif_a.yuv_de, vif_a.yuv_y, vif_a.yuv_c}, last_avg);
            check("pix_cos", {vif_c.yuv_hs, vif_c.yuv_vs, vif_c.yuv_de, vif_c.yuv_y, vif_c.yuv_c}, last_cos);
         end
      end else begin
         check("hold_avg", {vif_a.yuv_hs, vif_a.yuv_vs, vif_a.yuv_de, vif_a.yuv_y, vif_a.yuv_c}, last_avg);
         check("hold_cos", {vif_c.yuv_hs, vif_c.yuv_vs, vif_c.yuv_de, vif_c.yuv_y, vif_c.yuv_c}, last_cos);
      end
   endtask

   task automatic pix(input logic [23:0] dat);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, dat);
   endtask

   // Blanking cycles with hs asserted; vs optionally asserted too.
   task automatic gap(input int n, input logic vs);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1, vs, BLACK);
   endtask

   initial begin
      rst = 1'b1;
      cke = 1'b0;
      vif_a.rgb_de = 1'b0;  vif_a.rgb_hs = 1'b0;  vif_a.rgb_vs = 1'b0;  vif_a.rgb_dat = '0;
      vif_c.rgb_de = 1'b0;  vif_c.rgb_hs = 1'b0;  vif_c.rgb_vs = 1'b0;  vif_c.rgb_dat = '0;
      prev_de = 1'b0;  prev_ph = 1'b0;  have_pend = 1'b0;
      hold_avg = 10'd512;  hold_cos = 10'd512;
      last_avg = BLANK;    last_cos = BLANK;

      // Reset held with active white input and syncs high: outputs stay blank.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, WHITE);

      // First line right after release: de must appear exactly four edges later.
      pix(WHITE); pix(WHITE); pix(WHITE); pix(WHITE);
      gap(1, 1'b1);
      pix(BLACK); pix(BLACK);
      gap(1, 1'b0);
      pix(RED); pix(RED); pix(RED); pix(RED);
      gap(1, 1'b0);
      pix(BLUE); pix(BLUE); pix(BLUE); pix(BLUE);
      gap(1, 1'b0);

      // Mixed pairs: averaging differs from co-siting.
      pix(RED); pix(BLUE); pix(BLUE); pix(RED); pix(GREEN); pix(WHITE);
      gap(1, 1'b0);

      // Odd-length line: last even pixel is unpaired; next line restarts even.
      pix(WHITE); pix(WHITE); pix(WHITE);
      gap(1, 1'b0);
      pix(RED); pix(BLUE); pix(GREEN);
      gap(2, 1'b0);

      // Single-pixel lines separated by single gaps.
      pix(BLUE);
      gap(1, 1'b0);
      pix(RED);
      gap(1, 1'b0);

      // Clock-enable toggling: data on disabled edges must be ignored.
      for (int i = 0; i < 16; i++) begin
         logic [23:0] d;
         d = (i % 3 == 0) ? RED : ((i % 3 == 1) ? BLUE : GREEN);
         if (i % 2 == 1) d = 24'h123456 ^ 24'(i);
         step(1'b0, (i % 2 == 0), 1'b1, 1'b0, 1'b0, d);
      end
      for (int i = 0; i < 8; i++) step(1'b0, (i % 2 == 0), 1'b0, 1'b1, 1'b0, BLACK);

      // Reset mid-line: in-flight pixels are discarded.
      pix(RED); pix(GREEN); pix(BLUE);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, WHITE);
      gap(5, 1'b0);
      pix(GREEN); pix(RED);
      gap(2, 1'b0);

      // Random colours, random line lengths, 1-2 cycle gaps.
      for (int l = 0; l < 6; l++) begin
         int len;
         len = int'($urandom_range(1, 7));
         for (int p = 0; p < len; p++) pix(24'($urandom));
         gap(int'($urandom_range(1, 2)), (l == 5));
      end

      // Flush the pipeline.
      gap(6, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
